// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_acc;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_busy;
    logic             r_done;
    logic             w_d;
    logic             w_last;

    assign w_d    = r_ra[0] ^ r_rb[0] ^ r_br;
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // busy/done are registered from the state, so they trail it by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ra   <= '0;
            r_rb   <= '0;
            r_acc  <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (r_state == SHIFT);
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ra  <= a;
                        r_rb  <= b;
                        r_br  <= 1'b0;
                        r_cnt <= '0;
                        r_acc <= '0;
                    end
                end
                SHIFT: begin
                    r_br  <= (~r_ra[0] & r_rb[0]) | (~(r_ra[0] ^ r_rb[0]) & r_br);
                    r_acc <= {w_d, r_acc[WIDTH-1:1]};
                    r_ra  <= {1'b0, r_ra[WIDTH-1:1]};
                    r_rb  <= {1'b0, r_rb[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_diff <= r_acc;
                    r_bout <= r_br;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_amsb;
    logic r_bmsb;
    logic r_ovf;

    // Operand sign bits are shifted out during SHIFT, so keep the captured copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_amsb <= a[WIDTH-1];
                r_bmsb <= b[WIDTH-1];
            end
            if (r_state == DONE)
                r_ovf <= (r_amsb != r_bmsb) && (r_acc[WIDTH-1] != r_amsb);
        end
    end

    assign ovf = r_ovf;
`endif

    assign diff = r_diff;
    assign bout = r_bout;
    assign busy = r_busy;
    assign done = r_done;

endmodule
